// File: rtl/conv_window_mover.sv
// Feature-map window mover: walks a multi-channel map in single-port memory and
// streams one KH x KW window per (output position, channel) over valid/ready.
module conv_window_mover #(
   parameter int KH     = 5,
   parameter int KW     = 5,
   parameter int IF_BW  = 8,
   parameter int AW     = 16,
   parameter int DIM_BW = 8,
   parameter int CH_BW  = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   i_run,
   input  logic [AW-1:0]          i_base_addr,
   input  logic [DIM_BW-1:0]      i_in_w,
   input  logic [DIM_BW-1:0]      i_in_h,
   input  logic [DIM_BW-1:0]      i_stride,
   input  logic [CH_BW-1:0]       i_ch,
   output logic                   o_mem_ce,
   output logic [AW-1:0]          o_mem_addr,
   input  logic [IF_BW-1:0]       i_mem_dout,
   output logic                   o_valid,
   input  logic                   i_ready,
   output logic [KH*KW*IF_BW-1:0] o_window,
   output logic                   o_last_ch,
   output logic                   o_last,
   output logic                   o_busy,
   output logic                   o_done,
   output logic                   o_err
);

   localparam int N   = KH * KW;
   localparam int KIW = (N > 1) ? $clog2(N) : 1;
   localparam int XW  = DIM_BW + 2;
   localparam logic [KIW-1:0] K_LAST  = KIW'(N - 1);
   localparam logic [7:0]     KX_LAST = 8'(KW - 1);
   localparam logic [XW-1:0]  KW_X    = XW'(KW);
   localparam logic [XW-1:0]  KH_X    = XW'(KH);

   // Handshake: a window transfers on any rising edge where o_valid && i_ready;
   // o_valid is a pure function of state and never looks at i_ready.
   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DRAIN, S_VALID, S_DONE} state_t;
   state_t state_q, state_d;

   logic [AW-1:0]          base_q, hw_q, sw_q, choff_q, rowoff_q, kyoff_q;
   logic [DIM_BW-1:0]      w_q, h_q, s_q, col_q, y_q;
   logic [CH_BW-1:0]       ch_cfg_q, ch_q;
   logic                   err_q;
   logic [7:0]             kx_q;
   logic [KIW-1:0]         k_q, rd_idx_q;
   logic                   rd_vld_q;
   logic [IF_BW-1:0]       win_q [N];
   logic [2*DIM_BW-1:0]    hw_full, sw_full;
   logic                   cfg_bad, last_ch, ox_last, oy_last, last_win, fetch_end;

   assign hw_full   = (2*DIM_BW)'(i_in_w) * (2*DIM_BW)'(i_in_h);
   assign sw_full   = (2*DIM_BW)'(i_stride) * (2*DIM_BW)'(i_in_w);
   assign cfg_bad   = (XW'(i_in_w) < KW_X) || (XW'(i_in_h) < KH_X) ||
                      (i_stride == '0) || (i_ch == '0);
   // Stepping one more stride must still leave a whole kernel inside the map.
   assign last_ch   = (ch_q == ch_cfg_q - CH_BW'(1));
   assign ox_last   = (XW'(col_q) + XW'(s_q) + KW_X) > XW'(w_q);
   assign oy_last   = (XW'(y_q) + XW'(s_q) + KH_X) > XW'(h_q);
   assign last_win  = last_ch && ox_last && oy_last;
   assign fetch_end = (k_q == K_LAST);

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (i_run) state_d = cfg_bad ? S_DONE : S_FETCH;
         S_FETCH: if (fetch_end) state_d = S_DRAIN;
         S_DRAIN: state_d = S_VALID;
         S_VALID: if (i_ready) state_d = last_win ? S_DONE : S_FETCH;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      o_mem_ce   = (state_q == S_FETCH);
      o_mem_addr = '0;
      if (o_mem_ce)
         o_mem_addr = base_q + choff_q + rowoff_q + AW'(col_q) + kyoff_q + AW'(kx_q);
      o_valid   = (state_q == S_VALID);
      o_last_ch = o_valid && last_ch;
      o_last    = o_valid && last_win;
      o_busy    = (state_q != S_IDLE);
      o_done    = (state_q == S_DONE);
      o_err     = o_done && err_q;
      o_window  = '0;
      for (int k = 0; k < N; k++) o_window[k*IF_BW +: IF_BW] = win_q[k];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         base_q   <= '0;  hw_q    <= '0;  sw_q     <= '0;
         w_q      <= '0;  h_q     <= '0;  s_q      <= '0;
         ch_cfg_q <= '0;  err_q   <= 1'b0;
         ch_q     <= '0;  col_q   <= '0;  y_q      <= '0;
         choff_q  <= '0;  rowoff_q <= '0; kyoff_q  <= '0;
         kx_q     <= '0;  k_q     <= '0;
         rd_vld_q <= 1'b0; rd_idx_q <= '0;
         for (int k = 0; k < N; k++) win_q[k] <= '0;
      end else begin
         state_q  <= state_d;
         // Read data returns one cycle after the request; tag it with its slot.
         rd_vld_q <= (state_q == S_FETCH);
         rd_idx_q <= k_q;
         if (rd_vld_q) win_q[rd_idx_q] <= i_mem_dout;

         if (state_q == S_IDLE && i_run) begin
            base_q   <= i_base_addr;
            w_q      <= i_in_w;
            h_q      <= i_in_h;
            s_q      <= i_stride;
            ch_cfg_q <= i_ch;
            hw_q     <= AW'(hw_full);
            sw_q     <= AW'(sw_full);
            err_q    <= cfg_bad;
            ch_q     <= '0;  col_q   <= '0;  y_q     <= '0;
            choff_q  <= '0;  rowoff_q <= '0; kyoff_q <= '0;
            kx_q     <= '0;  k_q     <= '0;
         end

         if (state_q == S_FETCH) begin
            if (fetch_end) begin
               k_q     <= '0;
               kx_q    <= '0;
               kyoff_q <= '0;
            end else begin
               k_q <= k_q + KIW'(1);
               if (kx_q == KX_LAST) begin
                  kx_q    <= '0;
                  kyoff_q <= kyoff_q + AW'(w_q);
               end else begin
                  kx_q <= kx_q + 8'd1;
               end
            end
         end

         // Channel innermost, then output column, then output row.
         if (state_q == S_VALID && i_ready) begin
            if (last_ch) begin
               ch_q    <= '0;
               choff_q <= '0;
               if (ox_last) begin
                  col_q    <= '0;
                  y_q      <= y_q + s_q;
                  rowoff_q <= rowoff_q + sw_q;
               end else begin
                  col_q <= col_q + s_q;
               end
            end else begin
               ch_q    <= ch_q + CH_BW'(1);
               choff_q <= choff_q + hw_q;
            end
         end
      end
   end

endmodule

// File: tb/tb_conv_window_mover.sv
// Directed bench for conv_window_mover: memory model, per-read address checks,
// expected-window queue and hand-computed scenario results.
module tb_conv_window_mover;

   localparam int KH = 5, KW = 5, IF_BW = 8, AW = 16, DIM_BW = 8, CH_BW = 4;
   localparam int N  = KH * KW;
   localparam int WB = KH * KW * IF_BW;

   logic              clk = 1'b0;
   logic              rst, i_run, i_ready;
   logic [AW-1:0]     i_base_addr;
   logic [DIM_BW-1:0] i_in_w, i_in_h, i_stride;
   logic [CH_BW-1:0]  i_ch;
   logic              o_mem_ce;
   logic [AW-1:0]     o_mem_addr;
   logic [IF_BW-1:0]  i_mem_dout = '0;
   logic              o_valid, o_last_ch, o_last, o_busy, o_done, o_err;
   logic [WB-1:0]     o_window;

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;
   int t0     = 0;

   logic [WB-1:0] exp_q [$];
   logic [WB-1:0] got_q [$];
   logic [AW-1:0] tl_q  [$];
   int            rise_q [$];
   logic          last_q [$];
   logic          lch_q  [$];

   conv_window_mover #(
      .KH(KH), .KW(KW), .IF_BW(IF_BW), .AW(AW), .DIM_BW(DIM_BW), .CH_BW(CH_BW)
   ) dut (
      .clk(clk), .rst(rst), .i_run(i_run), .i_base_addr(i_base_addr),
      .i_in_w(i_in_w), .i_in_h(i_in_h), .i_stride(i_stride), .i_ch(i_ch),
      .o_mem_ce(o_mem_ce), .o_mem_addr(o_mem_addr), .i_mem_dout(i_mem_dout),
      .o_valid(o_valid), .i_ready(i_ready), .o_window(o_window),
      .o_last_ch(o_last_ch), .o_last(o_last), .o_busy(o_busy),
      .o_done(o_done), .o_err(o_err)
   );

   // ---------------- clock / memory model ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [IF_BW-1:0] mem_f(input logic [AW-1:0] a);
      return a[7:0] ^ a[15:8];
   endfunction

   // Data is only meaningful the cycle after a read; otherwise it is noise.
   always @(posedge clk)
      i_mem_dout <= o_mem_ce ? mem_f(o_mem_addr) : IF_BW'($urandom);

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic logic [AW-1:0] exp_addr(input logic [AW-1:0] base, input int w, h, s,
                                              input int c, ox, oy, k);
      int a;
      a = int'(base) + c*h*w + (oy*s + k/KW)*w + ox*s + k%KW;
      return AW'(a);
   endfunction

   // ---------------- driver tasks ----------------
   task automatic do_run(input logic [AW-1:0] base, input int w, h, s, ch, input int bp_win);
      int ow, oh, total, rd, st, c, ox, oy;
      logic [WB-1:0] ev, held;
      ow = (w - KW) / s + 1;
      oh = (h - KH) / s + 1;
      total = ow * oh * ch;
      exp_q.delete(); got_q.delete(); tl_q.delete();
      rise_q.delete(); last_q.delete(); lch_q.delete();
      for (int i = 0; i < total; i++) begin
         c = i % ch; ox = (i / ch) % ow; oy = i / (ch * ow);
         for (int k = 0; k < N; k++)
            ev[k*IF_BW +: IF_BW] = mem_f(exp_addr(base, w, h, s, c, ox, oy, k));
         exp_q.push_back(ev);
      end
      @(negedge clk);
      i_base_addr = base; i_in_w = DIM_BW'(w); i_in_h = DIM_BW'(h);
      i_stride = DIM_BW'(s); i_ch = CH_BW'(ch); i_run = 1'b1;
      @(negedge clk);
      i_run = 1'b0;
      i_base_addr = AW'($urandom); i_in_w = DIM_BW'($urandom_range(0, 255));
      i_stride = '0; i_ch = '0;
      t0 = cyc;
      check("busy_start", o_busy, 1);
      for (int i = 0; i < total; i++) begin
         c = i % ch; ox = (i / ch) % ow; oy = i / (ch * ow);
         rd = 0;
         st = cyc;
         check("first_rd_ce", o_mem_ce, 1);
         for (int t = 0; t < 200 && !o_valid; t++) begin
            if (o_mem_ce) begin
               if (rd == 0) tl_q.push_back(o_mem_addr);
               if (rd < N) check("rd_addr", o_mem_addr, exp_addr(base, w, h, s, c, ox, oy, rd));
               else check("extra_read", rd, N - 1);
               rd++;
            end
            @(negedge clk);
         end
         if (!o_valid) begin
            check("valid_timeout", 0, 1);
            return;
         end
         check("valid_lat", cyc - st, N + 1);
         check("n_reads", rd, N);
         check("ce_in_valid", o_mem_ce, 0);
         rise_q.push_back(cyc + 1);
         last_q.push_back(o_last);
         lch_q.push_back(o_last_ch);
         got_q.push_back(o_window);
         check("window", o_window, exp_q.pop_front());
         check("last_ch", o_last_ch, (c == ch - 1));
         check("last", o_last, (i == total - 1));
         if (i == bp_win) begin
            held = o_window;
            i_ready = 1'b0;
            repeat (10) begin
               @(negedge clk);
               check("bp_window", o_window, held);
               check("bp_ce", o_mem_ce, 0);
               check("bp_valid", o_valid, 1);
            end
            i_ready = 1'b1;
         end
         @(negedge clk);
      end
      check("done", o_done, 1);
      check("done_err", o_err, 0);
      @(negedge clk);
      check("idle_busy", o_busy, 0);
      check("done_pulse", o_done, 0);
   endtask

   task automatic run_invalid(input int w, h, s, ch);
      @(negedge clk);
      i_base_addr = '0; i_in_w = DIM_BW'(w); i_in_h = DIM_BW'(h);
      i_stride = DIM_BW'(s); i_ch = CH_BW'(ch); i_run = 1'b1;
      @(negedge clk);
      check("inv_done", o_done, 1);
      check("inv_err", o_err, 1);
      check("inv_ce", o_mem_ce, 0);
      check("inv_busy", o_busy, 1);
      // Valid config presented while still busy must be ignored.
      i_in_w = 8'd5; i_in_h = 8'd5; i_stride = 8'd1; i_ch = 4'd1;
      @(negedge clk);
      i_run = 1'b0;
      check("inv_idle", o_busy, 0);
      check("inv_done_off", o_done, 0);
      check("inv_err_off", o_err, 0);
      @(negedge clk);
      check("inv_run_ignored", o_busy, 0);
      check("inv_ce_off", o_mem_ce, 0);
   endtask

   task automatic check_s1();
      logic [WB-1:0] hv;
      for (int k = 0; k < N; k++) hv[k*IF_BW +: IF_BW] = IF_BW'(k);
      do_run(16'h0000, 5, 5, 1, 1, -1);
      check("s1_lat", rise_q[0] - t0, 27);
      check("s1_window", got_q[0], hv);
      check("s1_last", last_q[0], 1);
      check("s1_last_ch", lch_q[0], 1);
      check("s1_tl", tl_q[0], 16'h0000);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      logic [AW-1:0] tl2 [4];
      logic [AW-1:0] tl3 [6];
      logic          lc3 [6];
      tl2 = '{16'd0, 16'd2, 16'd14, 16'd16};
      tl3 = '{16'h100, 16'h11E, 16'h13C, 16'h101, 16'h11F, 16'h13D};
      lc3 = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

      rst = 1'b1; i_run = 1'b0; i_ready = 1'b1;
      i_base_addr = '0; i_in_w = '0; i_in_h = '0; i_stride = '0; i_ch = '0;
      repeat (3) @(negedge clk);
      check("rst_ce", o_mem_ce, 0);
      check("rst_addr", o_mem_addr, 0);
      check("rst_valid", o_valid, 0);
      check("rst_window", o_window, 0);
      check("rst_busy", o_busy, 0);
      check("rst_done", o_done, 0);
      check("rst_err", o_err, 0);
      check("rst_last", {o_last, o_last_ch}, 0);
      rst = 1'b0;

      // 5x5, 1 channel, stride 1
      check_s1();

      // 7x7, stride 2: four windows, 27 cycles apart
      do_run(16'h0000, 7, 7, 2, 1, -1);
      for (int i = 0; i < 4; i++) begin
         check("s2_tl", tl_q[i], tl2[i]);
         check("s2_last", last_q[i], (i == 3));
      end
      for (int i = 0; i < 3; i++) check("s2_period", rise_q[i+1] - rise_q[i], 27);

      // 6x5, 3 channels, base 0x100, backpressure on window 2
      do_run(16'h0100, 6, 5, 1, 3, 1);
      for (int i = 0; i < 6; i++) begin
         check("s3_tl", tl_q[i], tl3[i]);
         check("s3_last_ch", lch_q[i], lc3[i]);
      end
      check("s3_last", last_q[5], 1);

      // Address wrap-around past the top of memory
      do_run(16'hFFF0, 5, 5, 1, 1, -1);
      check("wrap_tl", tl_q[0], 16'hFFF0);

      // Invalid configurations
      run_invalid(4, 5, 1, 1);
      run_invalid(5, 5, 0, 1);
      run_invalid(5, 5, 1, 0);

      // Reset during the fetch of the second window
      @(negedge clk);
      i_base_addr = '0; i_in_w = 8'd7; i_in_h = 8'd7; i_stride = 8'd2; i_ch = 4'd1;
      i_run = 1'b1;
      @(negedge clk);
      i_run = 1'b0;
      for (int t = 0; t < 100 && !o_valid; t++) @(negedge clk);
      check("rst_pre_valid", o_valid, 1);
      @(negedge clk);
      repeat (3) @(negedge clk);
      check("rst_pre_ce", o_mem_ce, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("mid_rst_ce", o_mem_ce, 0);
      check("mid_rst_addr", o_mem_addr, 0);
      check("mid_rst_valid", o_valid, 0);
      check("mid_rst_window", o_window, 0);
      check("mid_rst_busy", o_busy, 0);
      check("mid_rst_done", {o_done, o_err}, 0);
      check("mid_rst_last", {o_last, o_last_ch}, 0);
      check_s1();

      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
